// File: rtl/timer_pkg.sv
// Shared types and encodings for prescaled_event_timer and its sub-blocks.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for prescaled_event_timer: emits a tick every (i_div + 1) enabled cycles.
// i_clr has priority over i_en and returns the divider to 0.
module timer_prescaler #(
    parameter int unsigned PRE_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [PRE_W-1:0] i_div,
    output logic             o_tick
);

    logic [PRE_W-1:0] r_cnt;

    // >= rather than == so a divisor lowered mid-run cannot strand the count above it
    assign o_tick = i_en && (r_cnt >= i_div);

    // Divider state: clear, then wrap to 0 on tick, else increment while enabled
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + PRE_W'(1);
        end
    end

endmodule

// File: rtl/prescaled_event_timer.sv
// W-bit prescaled event timer: up/down, one-shot/periodic, synchronous load and a
// registered one-cycle terminal-count pulse. en_i is a global hold for every register.
// Optional capture unit (cap_i/cap_ack_i/cap_o/cap_ovr_o) is built when the macro
// TIMER_CAPTURE_EN is defined.
import timer_pkg::*;

module prescaled_event_timer #(
    parameter int unsigned W                = 10,
    parameter int unsigned PRE_W            = 4,
    parameter int unsigned ONE_SHOT_DEFAULT = 0
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             en_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             load_i,
    input  logic [W-1:0]     load_val_i,
    input  logic [W-1:0]     period_i,
    input  logic [PRE_W-1:0] pre_div_i,
    input  logic             dir_i,
    input  logic             oneshot_i,
    output logic [W-1:0]     count_o,
    output logic             tc_o,
    output logic             running_o,
    output logic             done_o
`ifdef TIMER_CAPTURE_EN
    ,
    input  logic             cap_i,
    input  logic             cap_ack_i,
    output logic [W-1:0]     cap_o,
    output logic             cap_ovr_o
`endif
);

    // ONE_SHOT_DEFAULT only documents the intended tie-off of oneshot_i
    if (W < 2 || ONE_SHOT_DEFAULT > 1) begin : g_bad_cfg
        $error("prescaled_event_timer: W must be >= 2 and ONE_SHOT_DEFAULT 0 or 1");
    end

    timer_state_t r_state;
    timer_state_t w_state_nxt;
    logic [W-1:0] r_count;
    logic [W-1:0] w_count_nxt;
    logic         r_tc;
    logic         w_tc_nxt;
    logic         w_running;
    logic         w_tick;
    logic         w_begin;
    logic         w_advance;
    logic         w_terminal;

    assign w_running  = (r_state == RUN);
    // start from IDLE or DONE; a simultaneous stop cancels it
    assign w_begin    = !w_running && start_i && !stop_i;
    // a tick only moves the count when the run continues and no load overrides it
    assign w_advance  = w_running && !stop_i && w_tick && !load_i;
    assign w_terminal = (dir_i == DIR_DOWN) ? (r_count == '0) : (r_count == period_i);
    assign w_tc_nxt   = w_advance && w_terminal;

    timer_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .i_clk  (CK),
        .i_rst  (RST),
        .i_en   (en_i && w_running),
        .i_clr  (en_i && (w_state_nxt != RUN)),
        .i_div  (pre_div_i),
        .o_tick (w_tick)
    );

    // Next-state decode; stop beats start everywhere
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, DONE: begin
                if (stop_i) begin
                    w_state_nxt = IDLE;
                end else if (start_i) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop_i) begin
                    w_state_nxt = IDLE;
                end else if (w_advance && w_terminal && oneshot_i) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Count mux: load > start initialisation > tick update
    always_comb begin
        w_count_nxt = r_count;
        if (load_i) begin
            w_count_nxt = load_val_i;
        end else if (w_begin) begin
            w_count_nxt = (dir_i == DIR_DOWN) ? period_i : '0;
        end else if (w_advance) begin
            if (w_terminal) begin
                // one-shot keeps the terminal value; periodic restarts the sweep
                if (!oneshot_i) begin
                    w_count_nxt = (dir_i == DIR_DOWN) ? period_i : '0;
                end
            end else if (dir_i == DIR_DOWN) begin
                w_count_nxt = r_count - W'(1);
            end else begin
                w_count_nxt = r_count + W'(1);
            end
        end
    end

    // Core registers; the terminal pulse is dropped rather than held while en_i is low
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (en_i) begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    assign count_o   = r_count;
    assign tc_o      = r_tc && en_i;
    assign running_o = (r_state == RUN);
    assign done_o    = (r_state == DONE);

`ifdef TIMER_CAPTURE_EN
    logic [W-1:0] r_cap;
    logic         r_cap_pend;
    logic         r_cap_ovr;

    // Capture snapshot plus pending/overrun flags; ack clears before a same-cycle capture
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_cap      <= '0;
            r_cap_pend <= 1'b0;
            r_cap_ovr  <= 1'b0;
        end else if (en_i) begin
            if (cap_i) begin
                r_cap <= r_count;
            end
            r_cap_pend <= cap_i || (r_cap_pend && !cap_ack_i);
            r_cap_ovr  <= (r_cap_ovr && !cap_ack_i) || (cap_i && r_cap_pend && !cap_ack_i);
        end
    end

    assign cap_o     = r_cap;
    assign cap_ovr_o = r_cap_ovr;
`endif

endmodule

// File: tb/tb_prescaled_event_timer.sv
// Self-checking bench for prescaled_event_timer: behavioural model checked every cycle
// plus literal expectations on directed scenarios.
module tb_prescaled_event_timer;

    localparam int W     = 10;
    localparam int PRE_W = 4;
    localparam int MAXV  = 1 << W;

    logic             CK = 1'b0;
    logic             RST = 1'b1;
    logic             en_i, start_i, stop_i, load_i, dir_i, oneshot_i;
    logic [W-1:0]     load_val_i, period_i;
    logic [PRE_W-1:0] pre_div_i;
    logic [W-1:0]     count_o;
    logic             tc_o, running_o, done_o;
`ifdef TIMER_CAPTURE_EN
    logic             cap_i, cap_ack_i, cap_ovr_o;
    logic [W-1:0]     cap_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    prescaled_event_timer #(
        .W                (W),
        .PRE_W            (PRE_W),
        .ONE_SHOT_DEFAULT (0)
    ) dut (
        .CK         (CK),
        .RST        (RST),
        .en_i       (en_i),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .period_i   (period_i),
        .pre_div_i  (pre_div_i),
        .dir_i      (dir_i),
        .oneshot_i  (oneshot_i),
        .count_o    (count_o),
        .tc_o       (tc_o),
        .running_o  (running_o),
        .done_o     (done_o)
`ifdef TIMER_CAPTURE_EN
        ,
        .cap_i      (cap_i),
        .cap_ack_i  (cap_ack_i),
        .cap_o      (cap_o),
        .cap_ovr_o  (cap_ovr_o)
`endif
    );

    always #5 CK = ~CK;

    // Model: st 0=idle 1=run 2=done; pre counts enabled RUN cycles since the last tick
    typedef struct {
        int st;
        int cnt;
        int pre;
        bit tc;
        int cap;
        bit cpend;
        bit covr;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t s);
        model_t n;
        bit     tick;
        bit     term;
        n    = s;
        n.tc = 1'b0;
        if (!en_i) return n;
`ifdef TIMER_CAPTURE_EN
        n.covr  = (s.covr && !cap_ack_i) || (cap_i && s.cpend && !cap_ack_i);
        n.cpend = cap_i || (s.cpend && !cap_ack_i);
        if (cap_i) n.cap = s.cnt;
`endif
        if (s.st == 1) begin
            if (stop_i) begin
                n.st  = 0;
                n.pre = 0;
            end else begin
                tick  = (s.pre == int'(pre_div_i));
                n.pre = tick ? 0 : s.pre + 1;
                if (tick && !load_i) begin
                    term = dir_i ? (s.cnt == 0) : (s.cnt == int'(period_i));
                    if (term) begin
                        n.tc = 1'b1;
                        if (oneshot_i) begin
                            n.st  = 2;
                            n.pre = 0;
                        end else begin
                            n.cnt = dir_i ? int'(period_i) : 0;
                        end
                    end else begin
                        n.cnt = dir_i ? (s.cnt + MAXV - 1) % MAXV : (s.cnt + 1) % MAXV;
                    end
                end
            end
        end else if (start_i && !stop_i) begin
            n.st  = 1;
            n.pre = 0;
            n.cnt = dir_i ? int'(period_i) : 0;
        end
        if (load_i) n.cnt = int'(load_val_i);
        return n;
    endfunction

    always @(posedge CK or posedge RST) begin
        if (RST) m <= '{default: 0};
        else     m <= model_next(m);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_count", int'(count_o), m.cnt);
        chk("model_tc", int'(tc_o), int'(m.tc && en_i));
        chk("model_running", int'(running_o), int'(m.st == 1));
        chk("model_done", int'(done_o), int'(m.st == 2));
`ifdef TIMER_CAPTURE_EN
        chk("model_cap", int'(cap_o), m.cap);
        chk("model_cap_ovr", int'(cap_ovr_o), int'(m.covr));
`endif
    endtask

    // One clock: let the edge happen, then compare on the falling edge
    task automatic step();
        @(posedge CK);
        @(negedge CK);
        if (!RST) check_model();
    endtask

    initial begin
        int exp1_cnt [10] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4};
        int exp1_tc  [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        int exp2_cnt [13] = '{2, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        int exp2_tc  [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        int exp2_done[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        int exp4_cnt [7]  = '{1021, 1022, 1023, 0, 1, 2, 0};
        int exp4_tc  [7]  = '{0, 0, 0, 0, 0, 0, 1};

        en_i = 1'b1; start_i = 1'b0; stop_i = 1'b0; load_i = 1'b0;
        load_val_i = '0; period_i = '0; pre_div_i = '0; dir_i = 1'b0; oneshot_i = 1'b0;
`ifdef TIMER_CAPTURE_EN
        cap_i = 1'b0; cap_ack_i = 1'b0;
`endif
        repeat (2) @(negedge CK);
        RST = 1'b0;
        chk("reset_count", int'(count_o), 0);
        chk("reset_tc", int'(tc_o), 0);
        chk("reset_running", int'(running_o), 0);
        chk("reset_done", int'(done_o), 0);

        // Up, periodic, period 5, no prescale
        period_i = 10'd5; start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("t1_start_count", int'(count_o), 0);
        chk("t1_start_running", int'(running_o), 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t1_count", int'(count_o), exp1_cnt[i]);
            chk("t1_tc", int'(tc_o), exp1_tc[i]);
        end
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;
        chk("t1_stop_running", int'(running_o), 0);
        step();
        chk("t1_stop_hold", int'(count_o), 4);

        // Down, one-shot, period 2, divide by 4
        pre_div_i = 4'd3; dir_i = 1'b1; oneshot_i = 1'b1; period_i = 10'd2; start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("t2_start_count", int'(count_o), 2);
        for (int i = 0; i < 13; i++) begin
            step();
            chk("t2_count", int'(count_o), exp2_cnt[i]);
            chk("t2_tc", int'(tc_o), exp2_tc[i]);
            chk("t2_done", int'(done_o), exp2_done[i]);
        end
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("t2_restart_count", int'(count_o), 2);
        chk("t2_restart_running", int'(running_o), 1);
        chk("t2_restart_done", int'(done_o), 0);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;

        // Hold enable frozen mid-run
        pre_div_i = 4'd0; dir_i = 1'b0; oneshot_i = 1'b0; period_i = 10'd7; start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (3) step();
        chk("t3_pre_hold", int'(count_o), 3);
        en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_hold_count", int'(count_o), 3);
            chk("t3_hold_running", int'(running_o), 1);
            chk("t3_hold_tc", int'(tc_o), 0);
        end
        en_i = 1'b1;
        step();
        chk("t3_resume", int'(count_o), 4);
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;

        // Load above period with start in the same cycle
        load_val_i = 10'd1020; load_i = 1'b1; period_i = 10'd2; start_i = 1'b1;
        step();
        load_i = 1'b0; start_i = 1'b0;
        chk("t4_load", int'(count_o), 1020);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t4_count", int'(count_o), exp4_cnt[i]);
            chk("t4_tc", int'(tc_o), exp4_tc[i]);
        end
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;

        // Period 0: terminal on every tick, both directions
        period_i = 10'd0; start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("p0_up_count", int'(count_o), 0);
            chk("p0_up_tc", int'(tc_o), 1);
        end
        stop_i = 1'b1;
        step();
        stop_i = 1'b0; dir_i = 1'b1; start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("p0_dn_count", int'(count_o), 0);
            chk("p0_dn_tc", int'(tc_o), 1);
        end
        stop_i = 1'b1;
        step();
        stop_i = 1'b0;

        // Start and stop together in IDLE
        start_i = 1'b1; stop_i = 1'b1;
        step();
        start_i = 1'b0; stop_i = 1'b0;
        chk("t5_start_stop", int'(running_o), 0);

        // Asynchronous reset mid-run
        dir_i = 1'b0; period_i = 10'd7; start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (4) step();
        chk("t5_pre_reset", int'(count_o), 4);
        #2 RST = 1'b1;
        #1;
        chk("t5_async_count", int'(count_o), 0);
        chk("t5_async_running", int'(running_o), 0);
        chk("t5_async_tc", int'(tc_o), 0);
        @(negedge CK);
        RST = 1'b0;
        step();
        chk("t5_after_reset", int'(running_o), 0);

`ifdef TIMER_CAPTURE_EN
        // Capture, overrun, acknowledge
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (3) step();
        cap_i = 1'b1;
        step();
        cap_i = 1'b0;
        chk("cap_value", int'(cap_o), 3);
        chk("cap_ovr_first", int'(cap_ovr_o), 0);
        step();
        cap_i = 1'b1;
        step();
        cap_i = 1'b0;
        chk("cap_second", int'(cap_o), 5);
        chk("cap_ovr_set", int'(cap_ovr_o), 1);
        cap_ack_i = 1'b1;
        step();
        cap_ack_i = 1'b0;
        chk("cap_ovr_clear", int'(cap_ovr_o), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
